pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_pkg.sv | 29 ++
 rtl/pll_lock_supervisor_if.sv | 34 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor_pkg
//  Description : Shared state encoding and widths for the PLL lock supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_lock_supervisor_pkg;

    localparam int c_CNT_W   = 24;
    localparam int c_RETRY_W = 3;

    localparam logic [2:0] c_ST_POWERUP   = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_RETRY     = 3'd4;
    localparam logic [2:0] c_ST_FAIL      = 3'd5;

    typedef enum logic [2:0] {
        ST_POWERUP   = c_ST_POWERUP,
        ST_WAIT_LOCK = c_ST_WAIT_LOCK,
        ST_STABLE    = c_ST_STABLE,
        ST_RUN       = c_ST_RUN,
        ST_RETRY     = c_ST_RETRY,
        ST_FAIL      = c_ST_FAIL
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor_if
//  Description : PLL areset/locked handshake plus system reset status bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_lock_supervisor_if;
    import pll_lock_supervisor_pkg::*;

    logic                 locked;
    logic                 pll_areset;
    logic                 sys_rst_n;
    logic                 lock_fail;
    logic [c_RETRY_W-1:0] retry_cnt;

    // master is the supervisor, slave is the PLL / reset fabric side
    modport master (
        input  locked,
        output pll_areset,
        output sys_rst_n,
        output lock_fail,
        output retry_cnt
    );

    modport slave (
        output locked,
        input  pll_areset,
        input  sys_rst_n,
        input  lock_fail,
        input  retry_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchronizer, async reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Holds the PLL in reset at power-up, qualifies lock, releases
//                system reset and retries on loss of lock with bounded count.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter logic [23:0] DELAY_TOP    = 24'd2500000,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd500000,
    parameter logic [15:0] LOCK_STABLE  = 16'd1024,
    parameter logic [7:0]  PLL_RST_CYC  = 8'd16,
    parameter logic [2:0]  RETRY_MAX    = 3'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master pll
);

    localparam logic [c_CNT_W-1:0] c_DELAY_LAST   = DELAY_TOP - 24'd1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = LOCK_TIMEOUT - 24'd1;
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = {8'd0, LOCK_STABLE} - 24'd1;
    localparam logic [c_CNT_W-1:0] c_RST_LAST     = {16'd0, PLL_RST_CYC} - 24'd1;

    logic                 w_locked_s;
    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_RETRY_W-1:0] r_retry_cnt;
    logic [c_RETRY_W-1:0] w_retry_next;
    logic                 r_retry_sat;
    logic                 w_retry_sat_next;
    logic                 w_retry_entry;
    logic                 w_timed;
    logic                 r_pll_areset;
    logic                 w_pll_areset;
    logic                 r_sys_rst_n;
    logic                 w_sys_rst_n;
    logic                 r_lock_fail;
    logic                 w_lock_fail;

    sync_2ff u_sync_locked (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll.locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_POWERUP: begin
                if (r_cnt == c_DELAY_LAST) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (w_locked_s)                   w_next = ST_STABLE;
                else if (r_cnt == c_TIMEOUT_LAST) w_next = ST_RETRY;
            end
            ST_STABLE: begin
                if (!w_locked_s)                 w_next = ST_WAIT_LOCK;
                else if (r_cnt == c_STABLE_LAST) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!w_locked_s) w_next = ST_RETRY;
            end
            ST_RETRY: begin
                if (r_retry_sat)              w_next = ST_FAIL;
                else if (r_cnt == c_RST_LAST) w_next = ST_WAIT_LOCK;
            end
            ST_FAIL: begin
                w_next = ST_FAIL;
            end
            default: begin
                w_next = ST_POWERUP;
            end
        endcase

        w_timed = (w_next == ST_POWERUP) || (w_next == ST_WAIT_LOCK) ||
                  (w_next == ST_STABLE)  || (w_next == ST_RETRY);
        w_cnt_next = ((w_next != r_state) || !w_timed) ? '0 : r_cnt + 24'd1;

        // retries exhausted is latched on RETRY entry, before the saturating bump
        w_retry_entry    = (w_next == ST_RETRY) && (r_state != ST_RETRY);
        w_retry_next     = r_retry_cnt;
        w_retry_sat_next = r_retry_sat;
        if (w_next == ST_RUN) begin
            w_retry_next     = '0;
            w_retry_sat_next = 1'b0;
        end else if (w_retry_entry) begin
            w_retry_sat_next = (r_retry_cnt == RETRY_MAX);
            if (r_retry_cnt != RETRY_MAX) w_retry_next = r_retry_cnt + 3'd1;
        end

        w_pll_areset = (w_next == ST_POWERUP) || (w_next == ST_RETRY) ||
                       (w_next == ST_FAIL);
        w_sys_rst_n  = (w_next == ST_RUN);
        w_lock_fail  = (w_next == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_POWERUP;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_retry_sat  <= 1'b0;
            r_pll_areset <= 1'b1;
            r_sys_rst_n  <= 1'b0;
            r_lock_fail  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_retry_cnt  <= w_retry_next;
            r_retry_sat  <= w_retry_sat_next;
            r_pll_areset <= w_pll_areset;
            r_sys_rst_n  <= w_sys_rst_n;
            r_lock_fail  <= w_lock_fail;
        end
    end

    assign pll.pll_areset = r_pll_areset;
    assign pll.sys_rst_n  = r_sys_rst_n;
    assign pll.lock_fail  = r_lock_fail;
    assign pll.retry_cnt  = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_supervisor
//  Description : Scoreboard bench for pll_lock_supervisor with small timings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc   = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        done  = 1'b0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [95:0] tag;
        logic        pa;
        logic        sr;
        logic        lf;
        logic [2:0]  rc;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor_if pll_bus ();

    pll_lock_supervisor #(
        .DELAY_TOP    (24'd100),
        .LOCK_TIMEOUT (24'd50),
        .LOCK_STABLE  (16'd8),
        .PLL_RST_CYC  (8'd4),
        .RETRY_MAX    (3'd2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pll   (pll_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input logic [31:0] c, input logic [95:0] tag,
                             input logic pa, input logic sr, input logic lf,
                             input logic [2:0] rc);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.pa  = pa;
        e.sr  = sr;
        e.lf  = lf;
        e.rc  = rc;
        sb.push_back(e);
    endtask

    // Monitor: expectations are stamped with the cycle they apply to
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_errors++;
                $display("FAIL %0s missed: due cycle %0d, now %0d", e.tag, e.cyc, cyc);
            end else if ({pll_bus.pll_areset, pll_bus.sys_rst_n, pll_bus.lock_fail, pll_bus.retry_cnt}
                         !== {e.pa, e.sr, e.lf, e.rc}) begin
                n_errors++;
                $display("FAIL %0s cycle %0d: got areset=%b sys_rst_n=%b lock_fail=%b retry=%0d, expected areset=%b sys_rst_n=%b lock_fail=%b retry=%0d",
                         e.tag, cyc, pll_bus.pll_areset, pll_bus.sys_rst_n, pll_bus.lock_fail,
                         pll_bus.retry_cnt, e.pa, e.sr, e.lf, e.rc);
            end
        end
        if (done) begin
            n_checks++;
            if (sb.size() != 0) begin
                n_errors++;
                $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, now cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t_r, t_l, t_d, t_e, t_f, t_g, t_h, t_j, t_k, t_n;
        pll_bus.locked = 1'b0;
        rst_n          = 1'b0;
        step(3);
        expect_at(cyc, "rst_hold", 1'b1, 1'b0, 1'b0, 3'd0);

        // Nominal lock
        rst_n = 1'b1;
        t_r   = cyc;
        expect_at(t_r + 99,  "t1_pre_rel", 1'b1, 1'b0, 1'b0, 3'd0);
        expect_at(t_r + 100, "t1_rel",     1'b0, 1'b0, 1'b0, 3'd0);
        step(120);
        t_l = cyc;
        pll_bus.locked = 1'b1;
        expect_at(t_l + 10, "t1_pre_run", 1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_l + 11, "t1_run",     1'b0, 1'b1, 1'b0, 3'd0);

        // Loss of lock in RUN, then relock
        step(20);
        t_d = cyc;
        pll_bus.locked = 1'b0;
        expect_at(t_d + 2, "t3_pre",   1'b0, 1'b1, 1'b0, 3'd0);
        expect_at(t_d + 3, "t3_retry", 1'b1, 1'b0, 1'b0, 3'd1);
        expect_at(t_d + 6, "t3_pulse", 1'b1, 1'b0, 1'b0, 3'd1);
        expect_at(t_d + 7, "t3_wait",  1'b0, 1'b0, 1'b0, 3'd1);
        step(10);
        t_e = cyc;
        pll_bus.locked = 1'b1;
        expect_at(t_e + 10, "t3_pre_run", 1'b0, 1'b0, 1'b0, 3'd1);
        expect_at(t_e + 11, "t3_run",     1'b0, 1'b1, 1'b0, 3'd0);

        // Mid-operation reset: outputs must fall in the same cycle
        step(20);
        t_f = cyc;
        rst_n          = 1'b0;
        pll_bus.locked = 1'b0;
        expect_at(t_f,     "t5_async", 1'b1, 1'b0, 1'b0, 3'd0);
        expect_at(t_f + 2, "t5_hold",  1'b1, 1'b0, 1'b0, 3'd0);
        step(3);
        t_g   = cyc;
        rst_n = 1'b1;
        expect_at(t_g + 99,  "t5_pre_rel", 1'b1, 1'b0, 1'b0, 3'd0);
        expect_at(t_g + 100, "t5_rel",     1'b0, 1'b0, 1'b0, 3'd0);

        // One-cycle lock glitch after 5 stable cycles
        step(110);
        t_h = cyc;
        pll_bus.locked = 1'b1;
        step(5);
        pll_bus.locked = 1'b0;
        step(1);
        pll_bus.locked = 1'b1;
        expect_at(t_h + 8,  "t2_wait",    1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_h + 11, "t2_no_run",  1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_h + 16, "t2_pre_run", 1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_h + 17, "t2_run",     1'b0, 1'b1, 1'b0, 3'd0);

        // Lock arriving on the timeout cycle
        step(19);
        t_j = cyc;
        rst_n          = 1'b0;
        pll_bus.locked = 1'b0;
        expect_at(t_j, "t6_async", 1'b1, 1'b0, 1'b0, 3'd0);
        step(2);
        t_k   = cyc;
        rst_n = 1'b1;
        step(147);
        pll_bus.locked = 1'b1;
        expect_at(t_k + 149, "t6_pre",     1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_k + 150, "t6_tie",     1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_k + 157, "t6_pre_run", 1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_k + 158, "t6_run",     1'b0, 1'b1, 1'b0, 3'd0);

        // Never lock: two retries then terminal failure
        step(18);
        rst_n          = 1'b0;
        pll_bus.locked = 1'b0;
        step(2);
        t_n   = cyc;
        rst_n = 1'b1;
        expect_at(t_n + 149, "t4_pre",    1'b0, 1'b0, 1'b0, 3'd0);
        expect_at(t_n + 150, "t4_p1",     1'b1, 1'b0, 1'b0, 3'd1);
        expect_at(t_n + 153, "t4_p1_hold",1'b1, 1'b0, 1'b0, 3'd1);
        expect_at(t_n + 154, "t4_p1_end", 1'b0, 1'b0, 1'b0, 3'd1);
        expect_at(t_n + 203, "t4_gap",    1'b0, 1'b0, 1'b0, 3'd1);
        expect_at(t_n + 204, "t4_p2",     1'b1, 1'b0, 1'b0, 3'd2);
        expect_at(t_n + 207, "t4_p2_hold",1'b1, 1'b0, 1'b0, 3'd2);
        expect_at(t_n + 208, "t4_p2_end", 1'b0, 1'b0, 1'b0, 3'd2);
        expect_at(t_n + 257, "t4_gap2",   1'b0, 1'b0, 1'b0, 3'd2);
        expect_at(t_n + 260, "t4_fail",   1'b1, 1'b0, 1'b1, 3'd2);
        expect_at(t_n + 400, "t4_hold",   1'b1, 1'b0, 1'b1, 3'd2);
        step(405);
        done = 1'b1;
    end

endmodule
`default_nettype wire
